// File: rtl/data_ram_responder_pkg.sv
// Shared types and helpers for the MEM-stage data-RAM responder.
// Latency: none (types and pure functions only).
// Backpressure: none (no state).
package data_ram_responder_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_word,
                                                   input logic [WORD_W-1:0] new_word,
                                                   input logic [SEL_W-1:0]  sel);
    logic [WORD_W-1:0] w;
    w = old_word;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) w[8*i +: 8] = new_word[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-RAM responder (slave).
// Latency: none (wiring only).
// Backpressure: master holds its request stable while stall_o is high.
interface data_ram_responder_if;
  import data_ram_responder_pkg::*;

  logic                ram_ce_i;
  logic                ram_we_i;
  logic [WORD_W-1:0]   ram_addr_i;
  logic [SEL_W-1:0]    ram_sel_i;
  logic [WORD_W-1:0]   ram_wdata_i;
  logic [WORD_W-1:0]   ram_rdata_o;
  logic                stall_o;
  logic                ack_o;
  logic                err_o;

  modport master (
    output ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_wdata_i,
    input  ram_rdata_o, stall_o, ack_o, err_o
  );

  modport slave (
    input  ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_wdata_i,
    output ram_rdata_o, stall_o, ack_o, err_o
  );
endinterface

// File: rtl/data_ram_responder_bank.sv
// Single-port byte-enabled word array, write-first (a write returns the merged word).
// Latency: 1 cycle, result registered on the access edge.
// Backpressure: none; caller enables one access per cycle at most.
module data_ram_responder_bank
  import data_ram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [SEL_W-1:0]  sel,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // One access per enabled edge: lane-masked write with merged read-back, or plain read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < SEL_W; i++) begin
          if (sel[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= merge_word(mem[idx], wdata, sel);
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/data_ram_responder.sv
// Data-RAM responder: IDLE/WAIT/RESP FSM with wait states; optional read buffer via DATA_RAM_FAST_READ_EN.
// Latency: ack WAIT_CYCLES+1 cycles after request (1 on a read-buffer hit); stall_o high until then.
// Backpressure: stall_o freezes the pipeline; a captured request always completes.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  data_ram_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  function automatic logic in_range(input logic [29:0] waddr);
    return {2'b00, waddr} < 32'(DEPTH_WORDS);
  endfunction

  state_e            state;
  req_t              cap_q;
  req_t              live;
  req_t              acc;
  logic [CW-1:0]     wcnt_q;
  logic              ack_q;
  logic              err_q;
  logic              hit_q;
  logic [WORD_W-1:0] hold_q;
  logic [WORD_W-1:0] bank_rdata;
  logic [WORD_W-1:0] buf_rdata;
  logic [WORD_W-1:0] resp_word;
  logic              fast_hit;
  logic              direct;
  logic              acc_en;
  logic              acc_ok;
  logic [AW-1:0]     acc_idx;
  logic              unused_addr_lsb;

  assign live = '{we: bus.ram_we_i, sel: bus.ram_sel_i, addr: bus.ram_addr_i, wdata: bus.ram_wdata_i};

  // The array is touched on the edge entering RESP: straight from the live request when IDLE
  // jumps to RESP, otherwise from the captured copy at the end of WAIT.
  assign acc             = (state == IDLE) ? live : cap_q;
  assign acc_ok          = in_range(acc.addr[31:2]);
  assign acc_idx         = acc.addr[AW+1:2];
  assign unused_addr_lsb = ^acc.addr[1:0];
  assign direct          = (WAIT_CYCLES == 0) || fast_hit;
  assign acc_en          = ((state == IDLE) && bus.ram_ce_i && direct) ||
                           ((state == WAIT) && (wcnt_q == '0));

  data_ram_responder_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk  (clk_i),
    .en   (acc_en && acc_ok),
    .we   (acc.we),
    .sel  (acc.sel),
    .idx  (acc_idx),
    .wdata(acc.wdata),
    .rdata(bank_rdata)
  );

  // Out-of-range responses read as zero; hold_q keeps the last word between acks.
  assign resp_word       = err_q ? '0 : (hit_q ? buf_rdata : bank_rdata);
  assign bus.ram_rdata_o = (state == RESP) ? resp_word : hold_q;
  assign bus.stall_o     = ((state == IDLE) && bus.ram_ce_i) || (state == WAIT);
  assign bus.ack_o       = ack_q;
  assign bus.err_o       = err_q;

  // Request FSM: capture in IDLE, count wait states, pulse ack/err in RESP.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      cap_q  <= '0;
      wcnt_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      hit_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      ack_q <= acc_en;
      err_q <= acc_en && !acc_ok;
      hit_q <= acc_en && (state == IDLE) && fast_hit;
      case (state)
        IDLE: begin
          if (bus.ram_ce_i) begin
            cap_q <= live;
            if (direct) begin
              state <= RESP;
            end else begin
              state  <= WAIT;
              wcnt_q <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wcnt_q == '0) state <= RESP;
          else              wcnt_q <= wcnt_q - CW'(1);
        end
        RESP: begin
          hold_q <= resp_word;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATA_RAM_FAST_READ_EN
  logic              buf_vld;
  logic [AW-1:0]     buf_idx;
  logic [WORD_W-1:0] buf_word;

  assign fast_hit  = bus.ram_ce_i && !bus.ram_we_i && buf_vld &&
                     in_range(bus.ram_addr_i[31:2]) && (buf_idx == bus.ram_addr_i[AW+1:2]);
  assign buf_rdata = buf_word;

  // Read buffer: filled by every in-range read, kept coherent by merging writes to its index.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_vld  <= 1'b0;
      buf_idx  <= '0;
      buf_word <= '0;
    end else begin
      if (acc_en && acc_ok && acc.we && buf_vld && (buf_idx == acc_idx)) begin
        buf_word <= merge_word(buf_word, acc.wdata, acc.sel);
      end
      if ((state == RESP) && !cap_q.we && !err_q) begin
        buf_vld  <= 1'b1;
        buf_idx  <= cap_q.addr[AW+1:2];
        buf_word <= resp_word;
      end
    end
  end
`else
  assign fast_hit  = 1'b0;
  assign buf_rdata = '0;
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench: two responders (wait states 1 or 3, and 0) driven with directed and random requests.
// Latency: expected stall count per request comes from a word-array reference model.
// Backpressure: requests are held until ack, then the next one may follow with no gap.
module tb_data_ram_responder;
  import data_ram_responder_pkg::*;

  localparam int DEPTH = 64;
`ifdef DATA_RAM_FAST_READ_EN
  localparam int WAIT_A = 3;
  localparam bit FAST   = 1'b1;
`else
  localparam int WAIT_A = 1;
  localparam bit FAST   = 1'b0;
`endif
  localparam int WAIT_B = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_ram_responder_if bus_a ();
  data_ram_responder_if bus_b ();

  logic [1:0]  ce_r;
  logic [1:0]  we_r;
  logic [31:0] addr_r [2];
  logic [31:0] wd_r   [2];
  logic [3:0]  sel_r  [2];

  assign bus_a.ram_ce_i    = ce_r[0];
  assign bus_a.ram_we_i    = we_r[0];
  assign bus_a.ram_addr_i  = addr_r[0];
  assign bus_a.ram_sel_i   = sel_r[0];
  assign bus_a.ram_wdata_i = wd_r[0];
  assign bus_b.ram_ce_i    = ce_r[1];
  assign bus_b.ram_we_i    = we_r[1];
  assign bus_b.ram_addr_i  = addr_r[1];
  assign bus_b.ram_sel_i   = sel_r[1];
  assign bus_b.ram_wdata_i = wd_r[1];

  data_ram_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus_a)
  );
  data_ram_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_B)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus_b)
  );

  logic [1:0]  ack_s, err_s, stall_s;
  logic [31:0] rd_s [2];
  assign ack_s   = {bus_b.ack_o, bus_a.ack_o};
  assign err_s   = {bus_b.err_o, bus_a.err_o};
  assign stall_s = {bus_b.stall_o, bus_a.stall_o};
  assign rd_s[0] = bus_a.ram_rdata_o;
  assign rd_s[1] = bus_b.ram_rdata_o;

  // Reference model: plain word arrays plus the "last in-range read index" for the buffer.
  logic [31:0] model [2][DEPTH];
  bit          bvld  [2];
  int          bidx  [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          stall_cnt [2];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every ack pops one expectation and checks data, error flag and stall length.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        stall_cnt[d] = 0;
      end else if (ack_s[d]) begin
        exp_t e;
        bit   got;
        got = 1'b0;
        if (d == 0 && q0.size() > 0) begin
          e = q0.pop_front(); got = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
          e = q1.pop_front(); got = 1'b1;
        end
        if (!got) begin
          checks++; errors++;
          $display("FAIL unexpected_ack dut%0d: got ack, required none", d);
        end else begin
          chk($sformatf("rdata dut%0d", d), rd_s[d], e.rdata);
          chk($sformatf("err dut%0d", d), {31'b0, err_s[d]}, {31'b0, e.err});
          chk($sformatf("stall_cycles dut%0d", d), 32'(stall_cnt[d]), 32'(e.stalls));
          chk($sformatf("stall_at_ack dut%0d", d), {31'b0, stall_s[d]}, 32'h0);
        end
        stall_cnt[d] = 0;
      end else if (stall_s[d]) begin
        stall_cnt[d]++;
      end
    end
  end

  task automatic issue(input int d, input bit we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wd);
    exp_t e;
    int   idx;
    bit   inr;
    bit   hit;
    bit   got;
    idx = int'(addr[31:2]);
    inr = (addr[31:2] < 30'(DEPTH));
    if (!inr) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
    end else begin
      e.err = 1'b0;
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
        end
      end
      e.rdata = model[d][idx];
    end
    hit      = FAST && !we && inr && bvld[d] && (bidx[d] == idx);
    e.stalls = hit ? 1 : (((d == 0) ? WAIT_A : WAIT_B) + 1);
    if (!we && inr) begin
      bvld[d] = 1'b1;
      bidx[d] = idx;
    end
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    ce_r[d] = 1'b1; we_r[d] = we; addr_r[d] = addr; sel_r[d] = sel; wd_r[d] = wd;
    got = 1'b0;
    for (int c = 0; c < 32 && !got; c++) begin
      @(negedge clk);
      if (ack_s[d]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout dut%0d addr %h: got no ack, required ack", d, addr);
    end
    @(posedge clk);
    #1;
    ce_r[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_addr [2];
    ce_r = '0; we_r = '0;
    for (int d = 0; d < 2; d++) begin
      addr_r[d] = '0; wd_r[d] = '0; sel_r[d] = '0;
      bvld[d] = 1'b0; bidx[d] = 0; stall_cnt[d] = 0; last_addr[d] = '0;
    end

    // Reset state of both responders.
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_rdata dut%0d", d), rd_s[d], 32'h0);
      chk($sformatf("reset_ack dut%0d", d), {31'b0, ack_s[d]}, 32'h0);
      chk($sformatf("reset_err dut%0d", d), {31'b0, err_s[d]}, 32'h0);
      chk($sformatf("reset_stall dut%0d", d), {31'b0, stall_s[d]}, 32'h0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // Give every word a known nonzero value.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) issue(d, 1'b1, 32'(i * 4), 4'hF, $urandom | 32'h1);
    end

    // Full write then read, partial lane write, empty-lane write.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0);
    issue(0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00);
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0);
    issue(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
    issue(0, 1'b0, 32'h13, 4'hF, 32'h0);

    // Out of range: dropped write, zero read with error, aliased word untouched.
    issue(0, 1'b1, 32'(4 * DEPTH), 4'hF, 32'h12345678);
    issue(0, 1'b0, 32'(4 * DEPTH), 4'hF, 32'h0);
    issue(0, 1'b0, 32'h0, 4'hF, 32'h0);
    issue(0, 1'b0, 32'hFFFFFFFC, 4'hF, 32'h0);

    // Repeated read, then byte write to the same word and read back.
    issue(0, 1'b0, 32'h40, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h40, 4'hF, 32'h0);
    issue(0, 1'b1, 32'h40, 4'b0001, 32'h000000A5);
    issue(0, 1'b0, 32'h40, 4'hF, 32'h0);

    // Zero wait states, back-to-back reads.
    issue(1, 1'b0, 32'h0, 4'hF, 32'h0);
    issue(1, 1'b0, 32'h4, 4'hF, 32'h0);
    issue(1, 1'b0, 32'h0, 4'hF, 32'h0);

    // Reset during the wait of a write: no ack, word keeps its old value.
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0);
    ce_r[0] = 1'b1; we_r[0] = 1'b1; addr_r[0] = 32'h20; sel_r[0] = 4'hF; wd_r[0] = ~model[0][8];
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midwait_reset_rdata", rd_s[0], 32'h0);
    chk("midwait_reset_ack", {31'b0, ack_s[0]}, 32'h0);
    chk("midwait_reset_err", {31'b0, err_s[0]}, 32'h0);
    ce_r[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bvld[0] = 1'b0;
    bvld[1] = 1'b0;
    idle(1);
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0);

    // Random traffic, biased towards reusing the previous address.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 200; n++) begin
        logic [31:0] a;
        int          pick;
        pick = $urandom_range(0, 99);
        if (pick < 30)      a = last_addr[d];
        else if (pick < 35) a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        else                a = 32'($urandom_range(0, DEPTH + 7) * 4 + $urandom_range(0, 3));
        last_addr[d] = a;
        issue(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        idle($urandom_range(0, 2));
      end
    end

    idle(4);
    chk("queue_drained dut0", 32'(q0.size()), 32'h0);
    chk("queue_drained dut1", 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
